mesi_snoop_controller: RTL and testbench

Bus-side counterpart of the CPU-side MESI FSM controller. It accepts snooped bus requests (RD/WR) issued by other caches and looks up the addressed line in the tag array. It flushes Modified data via a writeback handshake, downgrades or invalidates the local line state, and reports sharing status back to the bus. It sits between the shared bus and the tag/data arrays of one cache, alongside the CPU-side FSM controller.

---
 rtl/mesi_snoop_controller.sv | 156 +++++++++++++++
 tb/tb_mesi_snoop_controller.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesi_snoop_controller.sv
// Bus-side MESI snoop controller: looks up snooped lines, flushes Modified
// data through a writeback handshake, downgrades or invalidates the local
// copy and reports sharing status back to the bus.
module mesi_snoop_controller #(
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 4,
  parameter int INDEX_W  = 6,
  parameter int CNT_W    = 16,
  localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               snoop_valid_i,
  output logic               snoop_ready_o,
  input  logic [1:0]         snoop_type_i,
  input  logic [ADDR_W-1:0]  snoop_addr_i,
  output logic               lookup_en_o,
  output logic [INDEX_W-1:0] lookup_index_o,
  output logic [TAG_W-1:0]   lookup_tag_o,
  input  logic               tag_hit_i,
  input  logic [1:0]         tag_state_i,
  output logic               st_we_o,
  output logic [INDEX_W-1:0] st_index_o,
  output logic [1:0]         st_state_o,
  output logic               wb_valid_o,
  output logic [INDEX_W-1:0] wb_index_o,
  input  logic               wb_ready_i,
  output logic               resp_valid_o,
  output logic               bus_shared_o,
  output logic               flush_o,
  output logic [CNT_W-1:0]   hit_cnt_o
);

  typedef enum logic [2:0] {IDLE, LOOKUP, COMPARE, WB, UPDATE} state_e;

  localparam logic [1:0] MESI_I = 2'b00;
  localparam logic [1:0] MESI_S = 2'b01;
  localparam logic [1:0] MESI_M = 2'b11;

  localparam logic [1:0] SNOOP_RD = 2'b01;
  localparam logic [1:0] SNOOP_WR = 2'b10;

  state_e             state_q, state_d;
  logic               isWr_q, isWr_d;
  logic [INDEX_W-1:0] index_q, index_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               hit_q, hit_d;
  logic [1:0]         oldState_q, oldState_d;
  logic [1:0]         newState_q, newState_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               effHit;

  // Offset bits select a byte within the line and play no part in the lookup.
  logic unusedOffset;
  assign unusedOffset = ^snoop_addr_i[OFFSET_W-1:0];

  assign lookup_index_o = index_q;
  assign lookup_tag_o   = tag_q;
  assign st_index_o     = index_q;
  assign wb_index_o     = index_q;
  assign st_state_o     = newState_q;
  assign hit_cnt_o      = cnt_q;

  // State register plus latched request and lookup results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      isWr_q     <= 1'b0;
      index_q    <= '0;
      tag_q      <= '0;
      hit_q      <= 1'b0;
      oldState_q <= MESI_I;
      newState_q <= MESI_I;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      isWr_q     <= isWr_d;
      index_q    <= index_d;
      tag_q      <= tag_d;
      hit_q      <= hit_d;
      oldState_q <= oldState_d;
      newState_q <= newState_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state logic and Moore outputs; a miss is recorded as old state I so
  // that no flush or state write can follow it.
  always_comb begin
    state_d       = state_q;
    isWr_d        = isWr_q;
    index_d       = index_q;
    tag_d         = tag_q;
    hit_d         = hit_q;
    oldState_d    = oldState_q;
    newState_d    = newState_q;
    cnt_d         = cnt_q;
    effHit        = 1'b0;
    snoop_ready_o = 1'b0;
    lookup_en_o   = 1'b0;
    st_we_o       = 1'b0;
    wb_valid_o    = 1'b0;
    resp_valid_o  = 1'b0;
    bus_shared_o  = 1'b0;
    flush_o       = 1'b0;

    case (state_q)
      IDLE: begin
        snoop_ready_o = 1'b1;
        if (snoop_valid_i && (snoop_type_i == SNOOP_RD || snoop_type_i == SNOOP_WR)) begin
          isWr_d  = (snoop_type_i == SNOOP_WR);
          index_d = snoop_addr_i[OFFSET_W +: INDEX_W];
          tag_d   = snoop_addr_i[ADDR_W-1 -: TAG_W];
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        lookup_en_o = 1'b1;
        state_d     = COMPARE;
      end
      COMPARE: begin
        effHit     = tag_hit_i && (tag_state_i != MESI_I);
        hit_d      = effHit;
        oldState_d = effHit ? tag_state_i : MESI_I;
        if (!effHit) begin
          newState_d = MESI_I;
        end else if (isWr_q) begin
          newState_d = MESI_I;
        end else begin
          newState_d = MESI_S;
        end
        if (effHit && (cnt_q != {CNT_W{1'b1}})) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        state_d = (effHit && tag_state_i == MESI_M) ? WB : UPDATE;
      end
      WB: begin
        wb_valid_o = 1'b1;
        if (wb_ready_i) begin
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        resp_valid_o = 1'b1;
        st_we_o      = hit_q && (newState_q != oldState_q);
        bus_shared_o = hit_q;
        flush_o      = hit_q && (oldState_q == MESI_M);
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mesi_snoop_controller.sv
// Self-checking bench for mesi_snoop_controller: table of snoop vectors with
// expected responses pushed to a scoreboard, plus hand-written sequences for
// back-to-back requests, reset during writeback and counter saturation.
module tb_mesi_snoop_controller;

  localparam int ADDR_W   = 32;
  localparam int OFFSET_W = 4;
  localparam int INDEX_W  = 6;
  localparam int CNT_W    = 2;
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;

  logic               clk;
  logic               rst_n;
  logic               snoop_valid_i;
  logic               snoop_ready_o;
  logic [1:0]         snoop_type_i;
  logic [ADDR_W-1:0]  snoop_addr_i;
  logic               lookup_en_o;
  logic [INDEX_W-1:0] lookup_index_o;
  logic [TAG_W-1:0]   lookup_tag_o;
  logic               tag_hit_i;
  logic [1:0]         tag_state_i;
  logic               st_we_o;
  logic [INDEX_W-1:0] st_index_o;
  logic [1:0]         st_state_o;
  logic               wb_valid_o;
  logic [INDEX_W-1:0] wb_index_o;
  logic               wb_ready_i;
  logic               resp_valid_o;
  logic               bus_shared_o;
  logic               flush_o;
  logic [CNT_W-1:0]   hit_cnt_o;

  mesi_snoop_controller #(
    .ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W), .INDEX_W(INDEX_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .snoop_valid_i(snoop_valid_i), .snoop_ready_o(snoop_ready_o),
    .snoop_type_i(snoop_type_i), .snoop_addr_i(snoop_addr_i),
    .lookup_en_o(lookup_en_o), .lookup_index_o(lookup_index_o),
    .lookup_tag_o(lookup_tag_o), .tag_hit_i(tag_hit_i), .tag_state_i(tag_state_i),
    .st_we_o(st_we_o), .st_index_o(st_index_o), .st_state_o(st_state_o),
    .wb_valid_o(wb_valid_o), .wb_index_o(wb_index_o), .wb_ready_i(wb_ready_i),
    .resp_valid_o(resp_valid_o), .bus_shared_o(bus_shared_o), .flush_o(flush_o),
    .hit_cnt_o(hit_cnt_o)
  );

  typedef struct packed {
    logic        doReset;
    logic [1:0]  typ;
    logic [31:0] addr;
    logic        hit;
    logic [1:0]  state;
    logic [3:0]  wbDelay;
    logic        expShared;
    logic        expFlush;
    logic        expWe;
    logic [1:0]  expSt;
  } vec_t;

  typedef struct packed {
    logic       shared;
    logic       flush;
    logic       we;
    logic [1:0] st;
    logic [5:0] idx;
    logic [1:0] cnt;
  } exp_t;

  exp_t sbq[$];
  exp_t popped;
  vec_t vecs[11];
  int   nTests;
  int   nFails;
  int   expCnt;
  logic monOn;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkVec(input logic rs, input logic [1:0] typ, input logic [31:0] addr,
                                 input logic hit, input logic [1:0] st, input logic [3:0] wbd,
                                 input logic sh, input logic fl, input logic we, input logic [1:0] ns);
    vec_t v;
    v.doReset = rs; v.typ = typ; v.addr = addr; v.hit = hit; v.state = st;
    v.wbDelay = wbd; v.expShared = sh; v.expFlush = fl; v.expWe = we; v.expSt = ns;
    return v;
  endfunction

  // Expected response for an accepted snoop; counter model saturates at 3.
  task automatic pushExp(input vec_t v);
    exp_t e;
    if (v.expShared) expCnt = (expCnt == 3) ? 3 : expCnt + 1;
    e.shared = v.expShared;
    e.flush  = v.expFlush;
    e.we     = v.expWe;
    e.st     = v.expSt;
    e.idx    = v.addr[9:4];
    e.cnt    = expCnt[1:0];
    sbq.push_back(e);
  endtask

  // Response monitor: pops the scoreboard on every response pulse.
  always @(negedge clk) begin
    if (monOn) begin
      if (resp_valid_o) begin
        if (sbq.size() == 0) begin
          checkVal("unexpected resp_valid", 32'(resp_valid_o), 32'd0);
        end else begin
          popped = sbq.pop_front();
          checkVal("bus_shared", 32'(bus_shared_o), 32'(popped.shared));
          checkVal("flush", 32'(flush_o), 32'(popped.flush));
          checkVal("st_we", 32'(st_we_o), 32'(popped.we));
          if (popped.we) begin
            checkVal("st_state", 32'(st_state_o), 32'(popped.st));
            checkVal("st_index", 32'(st_index_o), 32'(popped.idx));
          end
          checkVal("hit_cnt", 32'(hit_cnt_o), 32'(popped.cnt));
        end
      end else begin
        checkVal("quiet outputs", {29'd0, bus_shared_o, flush_o, st_we_o}, 32'd0);
      end
    end
  end

  task automatic applyReset();
    @(posedge clk); #1;
    rst_n = 1'b0; snoop_valid_i = 1'b0; snoop_type_i = 2'b00; wb_ready_i = 1'b0;
    @(posedge clk);
    sbq.delete();
    expCnt = 0;
    @(negedge clk);
    monOn = 1'b1;
    checkVal("reset snoop_ready", 32'(snoop_ready_o), 32'd1);
    checkVal("reset outputs", {27'd0, lookup_en_o, st_we_o, wb_valid_o, resp_valid_o, flush_o}, 32'd0);
    checkVal("reset hit_cnt", 32'(hit_cnt_o), 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v);
    @(posedge clk); #1;
    snoop_valid_i = 1'b1; snoop_type_i = v.typ; snoop_addr_i = v.addr;
    tag_hit_i = v.hit; tag_state_i = v.state; wb_ready_i = 1'b0;
    if (v.typ == 2'b01 || v.typ == 2'b10) pushExp(v);
    @(negedge clk);
    checkVal("ready in idle", 32'(snoop_ready_o), 32'd1);
    @(posedge clk); #1;
    snoop_valid_i = 1'b0; snoop_type_i = 2'b00;
    if (!(v.typ == 2'b01 || v.typ == 2'b10)) begin
      @(negedge clk);
      checkVal("nop no lookup", 32'(lookup_en_o), 32'd0);
      checkVal("nop stays ready", 32'(snoop_ready_o), 32'd1);
      repeat (4) @(negedge clk);
      return;
    end
    @(negedge clk);
    checkVal("lookup_en T+1", 32'(lookup_en_o), 32'd1);
    checkVal("lookup_index", 32'(lookup_index_o), 32'(v.addr[9:4]));
    checkVal("lookup_tag", 32'(lookup_tag_o), 32'(v.addr[31:10]));
    checkVal("busy not ready", 32'(snoop_ready_o), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkVal("lookup_en pulse", 32'(lookup_en_o), 32'd0);
    @(posedge clk); #1;
    if (v.expFlush) begin
      for (int i = 0; i < int'(v.wbDelay); i++) begin
        @(negedge clk);
        checkVal("wb_valid waiting", 32'(wb_valid_o), 32'd1);
        checkVal("wb_index", 32'(wb_index_o), 32'(v.addr[9:4]));
        @(posedge clk); #1;
      end
      wb_ready_i = 1'b1;
      @(negedge clk);
      checkVal("wb_valid handshake", 32'(wb_valid_o), 32'd1);
      @(posedge clk); #1;
      wb_ready_i = 1'b0;
    end
    @(negedge clk);
    checkVal("resp timing", 32'(resp_valid_o), 32'd1);
    checkVal("no wb at resp", 32'(wb_valid_o), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkVal("resp pulse", 32'(resp_valid_o), 32'd0);
    checkVal("ready after resp", 32'(snoop_ready_o), 32'd1);
    checkVal("scoreboard drained", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    nTests = 0; nFails = 0; expCnt = 0; monOn = 1'b0;
    rst_n = 1'b0; snoop_valid_i = 1'b0; snoop_type_i = 2'b00; snoop_addr_i = '0;
    tag_hit_i = 1'b0; tag_state_i = 2'b00; wb_ready_i = 1'b0;

    //              rst  typ    addr           hit st     wbd sh fl we ns
    vecs[0]  = mkVec(1, 2'b01, 32'h1234_5670, 1, 2'b10, 0, 1, 0, 1, 2'b01);
    vecs[1]  = mkVec(0, 2'b10, 32'hABCD_E3A0, 1, 2'b11, 3, 1, 1, 1, 2'b00);
    vecs[2]  = mkVec(1, 2'b01, 32'h0000_0450, 0, 2'b01, 0, 0, 0, 0, 2'b00);
    vecs[3]  = mkVec(0, 2'b01, 32'h0000_0450, 1, 2'b01, 0, 1, 0, 0, 2'b01);
    vecs[4]  = mkVec(0, 2'b01, 32'hFFFF_FFF0, 1, 2'b11, 0, 1, 1, 1, 2'b01);
    vecs[5]  = mkVec(0, 2'b10, 32'h8000_0010, 1, 2'b01, 0, 1, 0, 1, 2'b00);
    vecs[6]  = mkVec(0, 2'b10, 32'h8000_0020, 1, 2'b00, 0, 0, 0, 0, 2'b00);
    vecs[7]  = mkVec(0, 2'b10, 32'h5555_5550, 1, 2'b10, 1, 1, 0, 1, 2'b00);
    vecs[8]  = mkVec(0, 2'b00, 32'h1111_1110, 1, 2'b10, 0, 0, 0, 0, 2'b00);
    vecs[9]  = mkVec(0, 2'b11, 32'h1111_1120, 1, 2'b11, 0, 0, 0, 0, 2'b00);
    vecs[10] = mkVec(0, 2'b01, 32'h2222_2220, 0, 2'b11, 0, 0, 0, 0, 2'b00);

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].doReset) applyReset();
      applyStimulus(vecs[i]);
    end

    // Request held while busy: second snoop accepted only at T+4.
    applyReset();
    @(posedge clk); #1;
    snoop_valid_i = 1'b1; snoop_type_i = 2'b01; snoop_addr_i = 32'h0000_0130;
    tag_hit_i = 1'b1; tag_state_i = 2'b10;
    pushExp(mkVec(0, 2'b01, 32'h0000_0130, 1, 2'b10, 0, 1, 0, 1, 2'b01));
    @(posedge clk); #1;
    snoop_addr_i = 32'h0000_0270;
    pushExp(mkVec(0, 2'b01, 32'h0000_0270, 1, 2'b10, 0, 1, 0, 1, 2'b01));
    @(negedge clk);
    checkVal("b2b first lookup", 32'(lookup_en_o), 32'd1);
    checkVal("b2b first index", 32'(lookup_index_o), 32'h13);
    @(posedge clk); #1;
    @(negedge clk);
    checkVal("b2b busy T+2", 32'(snoop_ready_o), 32'd0);
    checkVal("b2b no lookup T+2", 32'(lookup_en_o), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkVal("b2b busy T+3", 32'(snoop_ready_o), 32'd0);
    checkVal("b2b first resp", 32'(resp_valid_o), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    checkVal("b2b ready T+4", 32'(snoop_ready_o), 32'd1);
    @(posedge clk); #1;
    snoop_valid_i = 1'b0; snoop_type_i = 2'b00;
    @(negedge clk);
    checkVal("b2b second lookup", 32'(lookup_en_o), 32'd1);
    checkVal("b2b second index", 32'(lookup_index_o), 32'h27);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checkVal("b2b second resp", 32'(resp_valid_o), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    checkVal("b2b drained", 32'(sbq.size()), 32'd0);

    // Reset while a writeback is pending abandons it.
    @(posedge clk); #1;
    snoop_valid_i = 1'b1; snoop_type_i = 2'b10; snoop_addr_i = 32'h0000_03F0;
    tag_hit_i = 1'b1; tag_state_i = 2'b11; wb_ready_i = 1'b0;
    @(posedge clk); #1;
    snoop_valid_i = 1'b0; snoop_type_i = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checkVal("wb pending before reset", 32'(wb_valid_o), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    sbq.delete();
    expCnt = 0;
    @(negedge clk);
    checkVal("wb abandoned", 32'(wb_valid_o), 32'd0);
    checkVal("ready after wb reset", 32'(snoop_ready_o), 32'd1);
    checkVal("no resp after wb reset", 32'(resp_valid_o), 32'd0);
    checkVal("hit_cnt after wb reset", 32'(hit_cnt_o), 32'd0);
    rst_n = 1'b1;

    // Five hits on a 2-bit counter must stick at 3.
    applyReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(mkVec(0, 2'b01, 32'h0000_0040 + 32'(i * 16), 1, 2'b10, 0, 1, 0, 1, 2'b01));
    end
    checkVal("hit_cnt saturated", 32'(hit_cnt_o), 32'd3);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", nTests, nFails);
    $finish;
  end

endmodule
